// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if
//
// Bundles the two requester handshakes (instruction fetch and MEM stage)
// together with the memory-side bus of the shared unified memory.
//
// Handshake semantics: a requester raises its request (if_req, or
// d_read/d_write) together with address/data and holds all of them stable
// until it sees its one-cycle ready pulse (if_ready / d_ready). Read data
// (if_rdata / d_rdata) is valid in the ready cycle and stays unchanged until
// the next read completes for that same requester.
//
// Modports:
//   slave  - the arbiter: samples requests and mem_dout, drives ready,
//            rdata and the memory port.
//   master - the environment (pipeline stages plus memory).
interface unified_mem_arbiter_if;
  // instruction-fetch side
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  // data (MEM stage) side
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  // memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  modport slave (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_dout,
    output if_ready, if_rdata, d_ready, d_rdata,
           mem_addr, mem_din, mem_read, mem_write
  );

  modport master (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_dout,
    input  if_ready, if_rdata, d_ready, d_rdata,
           mem_addr, mem_din, mem_read, mem_write
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//
// Shares one single-ported unified memory (asynchronous read, synchronous
// write) between instruction fetch and the MEM stage. One access at a time:
// a request sampled in IDLE is latched, the memory port is held for
// MEM_LATENCY cycles (BUSY), then the owner gets a one-cycle ready (RESP).
// Occupancy per access is MEM_LATENCY+2 cycles.
//
// Ports:
//   clk         - rising-edge clock
//   reset       - synchronous, active-high
//   bus         - requester handshakes and memory port (slave modport)
//   dbg_state_o - current FSM state (0 IDLE, 1 BUSY, 2 RESP)
module unified_mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 4  // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 reset,
  unified_mem_arbiter_if.slave bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        owner_q;       // 0 = fetch, 1 = data
  logic        last_owner_q;  // owner of the most recent grant
  logic        op_write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        if_ready_q;
  logic        d_ready_q;
  logic        mem_read_q;
  logic        mem_write_q;

  logic d_req;
  logic grant_data_d;
  logic grant_write_d;

  // Read+write together counts as a write. On contention data wins unless
  // data had the previous grant, which alternates the two requesters.
  assign d_req         = bus.d_read | bus.d_write;
  assign grant_data_d  = d_req & (~bus.if_req | ~last_owner_q);
  assign grant_write_d = grant_data_d & bus.d_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      op_write_q   <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_req || bus.if_req) begin
            owner_q      <= grant_data_d;
            last_owner_q <= grant_data_d;
            op_write_q   <= grant_write_d;
            addr_q       <= grant_data_d ? bus.d_addr : bus.if_addr;
            wdata_q      <= bus.d_wdata;
            cnt_q        <= LAT_M1;
            mem_read_q   <= ~grant_write_d;
            // With a latency of 1 the first BUSY cycle is also the last,
            // so the write strobe must already be set on grant.
            mem_write_q  <= grant_write_d & (LAT_M1 == 4'd0);
            state_q      <= BUSY;
          end
        end

        BUSY: begin
          if (cnt_q == 4'd0) begin
            if (!op_write_q) begin
              if (owner_q) d_rdata_q  <= bus.mem_dout;
              else         if_rdata_q <= bus.mem_dout;
            end
            if_ready_q  <= ~owner_q;
            d_ready_q   <= owner_q;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= RESP;
          end else begin
            cnt_q       <= cnt_q - 4'd1;
            // Strobe lands in the cycle where the counter reads zero.
            mem_write_q <= op_write_q & (cnt_q == 4'd1);
          end
        end

        RESP: begin
          if_ready_q <= 1'b0;
          d_ready_q  <= 1'b0;
          state_q    <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // The latched address/data registers drive the memory directly, so they
  // naturally hold their last values outside BUSY.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = wdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter
//
// Directed bench for unified_mem_arbiter. Two instances: MEM_LATENCY=4
// (bus0) and MEM_LATENCY=1 (bus1), each with its own small memory model.
// Cycle 0 is the cycle a request is presented; the edge that ends it is the
// sampling edge. Outputs are sampled on the falling edge.
module tb_unified_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  always #5 clk = ~clk;

  unified_mem_arbiter_if bus0();
  unified_mem_arbiter_if bus1();
  logic [1:0] dbg0;
  logic [1:0] dbg1;

  unified_mem_arbiter #(.MEM_LATENCY(4)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .dbg_state_o(dbg0)
  );
  unified_mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .dbg_state_o(dbg1)
  );

  // ---------------- memory models ----------------
  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  assign bus0.mem_dout = mem0[bus0.mem_addr[9:2]];
  assign bus1.mem_dout = mem1[bus1.mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      mem0[8'h40] <= 32'h00500093;
      mem0[8'h80] <= 32'hA5A5A5A5;
      mem0[8'h0C] <= 32'h11111111;
      mem1[8'h40] <= 32'h12345678;
    end else begin
      if (bus0.mem_write) mem0[bus0.mem_addr[9:2]] <= bus0.mem_din;
      if (bus1.mem_write) mem1[bus1.mem_addr[9:2]] <= bus1.mem_din;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // per-cycle history of bus0, bit c = cycle c
  logic [31:0] rd_m, wr_m, ir_m, dr_m, zero_m;
  logic [31:0] addr_h   [0:31];
  logic [31:0] irdata_h [0:31];
  logic [31:0] drdata_h [0:31];

  task automatic sample(input int c);
    rd_m[c]     = bus0.mem_read;
    wr_m[c]     = bus0.mem_write;
    ir_m[c]     = bus0.if_ready;
    dr_m[c]     = bus0.d_ready;
    zero_m[c]   = ({bus0.mem_read, bus0.mem_write, bus0.if_ready, bus0.d_ready,
                    bus0.mem_addr, bus0.mem_din, bus0.if_rdata, bus0.d_rdata} == '0);
    addr_h[c]   = bus0.mem_addr;
    irdata_h[c] = bus0.if_rdata;
    drdata_h[c] = bus0.d_rdata;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drop_reqs();
    bus0.if_req  = 1'b0;
    bus0.d_read  = 1'b0;
    bus0.d_write = 1'b0;
  endtask

  // Runs n cycles on bus0 starting from the current (cycle 0) falling edge.
  // Requests drop after drop_after ready pulses; if_addr switches to
  // chg_addr after cycle chg_cycle; reset pulses after cycle rst_cycle.
  task automatic watch(input int n, input int drop_after, input int chg_cycle,
                       input logic [31:0] chg_addr, input int rst_cycle);
    int readies;
    readies = 0;
    rd_m = '0; wr_m = '0; ir_m = '0; dr_m = '0; zero_m = '0;
    sample(0);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      @(negedge clk);
      sample(c);
      if (bus0.if_ready || bus0.d_ready) begin
        readies++;
        if (readies == drop_after) drop_reqs();
      end
      if (c == chg_cycle) bus0.if_addr = chg_addr;
      if (c == rst_cycle) begin
        reset = 1'b1;
        drop_reqs();
      end
      if (c == rst_cycle + 1) reset = 1'b0;
    end
    drop_reqs();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd1_m, ir1_m, rdata1_h;

  initial begin
    reset = 1'b1;
    mem_init = 1'b1;
    drop_reqs();
    bus0.if_addr = '0; bus0.d_addr = '0; bus0.d_wdata = '0;
    bus1.if_req = 1'b0; bus1.d_read = 1'b0; bus1.d_write = 1'b0;
    bus1.if_addr = '0; bus1.d_addr = '0; bus1.d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;

    // reset state
    check("rst_ctl", 32'({bus0.mem_read, bus0.mem_write, bus0.if_ready, bus0.d_ready}), 32'h0);
    check("rst_addr", bus0.mem_addr, 32'h0);
    check("rst_din", bus0.mem_din, 32'h0);
    check("rst_irdata", bus0.if_rdata, 32'h0);
    check("rst_drdata", bus0.d_rdata, 32'h0);
    check("rst_state", 32'(dbg0), 32'h0);
    reset = 1'b0;

    // fetch read of 0x100 (word 0x40)
    bus0.if_req = 1'b1; bus0.if_addr = 32'h100;
    watch(8, 1, -1, 32'h0, -1);
    check("f_rd_mask", rd_m, 32'h0000001E);
    check("f_wr_mask", wr_m, 32'h0);
    check("f_ir_mask", ir_m, 32'h00000020);
    check("f_dr_mask", dr_m, 32'h0);
    check("f_addr", addr_h[3], 32'h100);
    check("f_rdata", irdata_h[5], 32'h00500093);

    // data write 0xDEADBEEF to 0x20
    bus0.d_write = 1'b1; bus0.d_addr = 32'h20; bus0.d_wdata = 32'hDEADBEEF;
    watch(8, 1, -1, 32'h0, -1);
    check("w_wr_mask", wr_m, 32'h00000010);
    check("w_rd_mask", rd_m, 32'h0);
    check("w_dr_mask", dr_m, 32'h00000020);
    check("w_ir_mask", ir_m, 32'h0);
    check("w_mem", mem0[8], 32'hDEADBEEF);

    // data read back of 0x20
    bus0.d_read = 1'b1; bus0.d_addr = 32'h20; bus0.d_wdata = 32'h0;
    watch(8, 1, -1, 32'h0, -1);
    check("r_rd_mask", rd_m, 32'h0000001E);
    check("r_dr_mask", dr_m, 32'h00000020);
    check("r_rdata", drdata_h[5], 32'hDEADBEEF);
    check("r_if_hold", irdata_h[5], 32'h00500093);

    // contention: data, fetch, data after reset clears last_owner
    pulse_reset();
    bus0.if_req = 1'b1; bus0.if_addr = 32'h100;
    bus0.d_read = 1'b1; bus0.d_addr = 32'h20;
    watch(20, 3, -1, 32'h0, -1);
    check("a_dr_mask", dr_m, 32'h00020020);
    check("a_ir_mask", ir_m, 32'h00000800);
    check("a_addr1", addr_h[2], 32'h20);
    check("a_addr2", addr_h[8], 32'h100);
    check("a_d_rdata", drdata_h[5], 32'hDEADBEEF);
    check("a_i_rdata", irdata_h[11], 32'h00500093);

    // reset in cycle 2 of a write to 0x30
    bus0.d_write = 1'b1; bus0.d_addr = 32'h30; bus0.d_wdata = 32'hCAFEF00D;
    watch(8, 1, -1, 32'h0, 2);
    check("x_wr_mask", wr_m, 32'h0);
    check("x_dr_mask", dr_m, 32'h0);
    check("x_zero_mask", zero_m, 32'h000001F8);
    check("x_mem", mem0[12], 32'h11111111);

    // if_addr changed during BUSY, request held for two accesses
    bus0.if_req = 1'b1; bus0.if_addr = 32'h100;
    watch(13, 2, 2, 32'h200, -1);
    check("c_rd_mask", rd_m, 32'h0000079E);
    check("c_ir_mask", ir_m, 32'h00000820);
    check("c_addr_busy", addr_h[4], 32'h100);
    check("c_addr_idle", addr_h[6], 32'h100);
    check("c_addr_new", addr_h[7], 32'h200);
    check("c_rdata1", irdata_h[5], 32'h00500093);
    check("c_rdata2", irdata_h[11], 32'hA5A5A5A5);

    // MEM_LATENCY = 1 fetch
    rd1_m = '0; ir1_m = '0; rdata1_h = '0;
    bus1.if_req = 1'b1; bus1.if_addr = 32'h100;
    rd1_m[0] = bus1.mem_read; ir1_m[0] = bus1.if_ready;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      rd1_m[c] = bus1.mem_read;
      ir1_m[c] = bus1.if_ready;
      if (bus1.if_ready) begin
        rdata1_h = bus1.if_rdata;
        bus1.if_req = 1'b0;
      end
    end
    bus1.if_req = 1'b0;
    check("l1_rd_mask", rd1_m, 32'h00000002);
    check("l1_ir_mask", ir1_m, 32'h00000004);
    check("l1_rdata", rdata1_h, 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
